fetch_pc: RTL
=============

# fetch_pc

Instruction-fetch front end for the single-cycle core. It owns the program counter, computes the next PC, and drives the word address into the asynchronous instruction memory. It returns the fetched instruction with a valid flag to decode/execute. It also handles stalls, branch/jump redirects, and fetch faults: misaligned targets and PCs outside the instruction-memory window.

## Interface
Parameters:
- IMEM_W, 13, byte-address width of instruction memory; the fetch window is 0 to 2**IMEM_W-1.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned and inside the window.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current PC (hazard or back-pressure).
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  32  byte address of the redirect.
- imem_raddr  out  IMEM_W  byte address to instruction memory, = pc[IMEM_W-1:0].
- imem_rdata  in  32  instruction word, combinational from imem_raddr.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, modulo 2**32.
- instr  out  32  imem_rdata when instr_valid, else NOP 32'h0000_0013.
- instr_valid  out  1  instr is a real fetched instruction.
- trap_cause  out  2  0 = none, 1 = misaligned redirect, 2 = PC out of range; sticky while in TRAP.
- trap_pc  out  32  offending address latched on trap entry.
- fetch_cnt  out  32  accepted-fetch counter (see Configuration).

## Operation
States:
- BOOT (reset state)
  - instr_valid = 0; PC held.
  - Exactly one cycle after rst is released, goes to RUN unconditionally.
  - stall and redirect are ignored in this state.
- RUN
  - instr_valid = 1 when pc[31:IMEM_W] == 0; otherwise 0.
  - Next-PC priority: rst > redirect_valid > stall > pc_plus4.
  - On redirect with redirect_target[1:0] != 0: PC unchanged, trap_cause <= 1, trap_pc <= redirect_target, go to TRAP.
  - When the current pc[31:IMEM_W] != 0, regardless of stall and redirect:
    - trap_cause <= 2, trap_pc <= pc, go to TRAP.
    - This check has priority over any redirect in the same cycle.
- TRAP
  - instr_valid = 0; instr = NOP; PC frozen; stall ignored.
  - Leaves only on a redirect whose target is aligned and inside the window: pc <= target, trap_cause <= 0, go to RUN.
  - A misaligned or out-of-range redirect in TRAP is ignored; trap_cause and trap_pc keep their first values.

Arithmetic:
- pc_plus4 wraps modulo 2**32.
- Sequential increment past 2**IMEM_W-4 reaches the out-of-range PC, which traps on the following cycle.
- A PC wrapping from 0xFFFF_FFFC to 0 is unreachable in practice, because the out-of-range trap fires first.

## Timing
- Reset values:
  - pc = RESET_PC, state = BOOT, instr_valid = 0, trap_cause = 0, trap_pc = 0, fetch_cnt = 0.
  - Outputs that are combinational from pc also follow their reset-value pc: imem_raddr = RESET_PC[IMEM_W-1:0], pc_plus4 = RESET_PC + 4, instr = NOP.
- Fetch latency is zero cycles. imem_raddr, pc_plus4, instr and instr_valid are combinational from pc and state in the same cycle.
- A redirect asserted in cycle N makes pc = target in cycle N+1; no instruction is fetched from the fall-through path after that.
- stall held for k cycles keeps pc and instr stable for k cycles; instr_valid stays 1.
- Stall and redirect together: redirect wins.
- rst asserted mid-operation, in any state, wins over everything. The next cycle shows the reset values, including TRAP being cleared.
- trap_cause and trap_pc become visible the cycle after the faulting condition.

## Configuration
- FETCH_PERF_EN defined:
  - fetch_cnt increments by 1 on every cycle with instr_valid = 1 and stall = 0.
  - Saturates at 32'hFFFF_FFFF; cleared only by rst.
- FETCH_PERF_EN undefined:
  - The fetch_cnt port remains, tied to 32'h0.
  - No counter register is synthesized.

## Test plan
- Reset release with RESET_PC = 0 and memory words 0x00500093, 0x00600113:
  - first cycle is BOOT: instr_valid = 0, instr = 0x00000013.
  - next cycle: pc = 0, instr = 0x00500093.
  - following cycle: pc = 4.
- At pc = 0x10: stall for 3 cycles, then assert stall and redirect to 0x40 in the same cycle:
  - pc stays 0x10 for 3 cycles;
  - then pc = 0x40, because redirect beats stall.
- Redirect to 0x42:
  - next cycle trap_cause = 1, trap_pc = 0x42, instr_valid = 0, pc unchanged;
  - a later redirect to 0x44 gives pc = 0x44, trap_cause = 0, RUN.
- Free-run with IMEM_W = 13 from 0x1FF8:
  - pc 0x1FF8, then 0x1FFC, then 0x2000 with instr_valid = 0;
  - the cycle after 0x2000 shows trap_cause = 2, trap_pc = 0x2000;
  - a redirect to 0x3000 while in TRAP is ignored.
- rst asserted for one cycle while in TRAP: all outputs return to reset values; BOOT then RUN from RESET_PC.
- With FETCH_PERF_EN, 10 unstalled valid fetches plus 4 stalled cycles give fetch_cnt = 10. Without the macro, fetch_cnt = 0.

Source files
------------

// File: rtl/fetch_pc_if.sv
// rtl/fetch_pc_if.sv - fetch front-end bundle: redirect/stall control, imem port and fetch results
interface fetch_pc_if #(
  parameter int IMEM_W = 13
);
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_target;
  logic [IMEM_W-1:0] imem_raddr;
  logic [31:0]       imem_rdata;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [1:0]        trap_cause;
  logic [31:0]       trap_pc;
  logic [31:0]       fetch_cnt;

  modport master (
    output stall, redirect_valid, redirect_target, imem_rdata,
    input  imem_raddr, pc, pc_plus4, instr, instr_valid, trap_cause, trap_pc, fetch_cnt
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_rdata,
    output imem_raddr, pc, pc_plus4, instr, instr_valid, trap_cause, trap_pc, fetch_cnt
  );
endinterface

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - PC owner with BOOT/RUN/TRAP sequencing and fetch-fault capture
// FETCH_PERF_EN adds a saturating accepted-fetch counter on fetch_cnt.
module fetch_pc #(
  parameter int          IMEM_W   = 13,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  fetch_pc_if.slave  bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, TRAP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  trap_cause_q, trap_cause_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic        pc_in_range;
  logic        tgt_aligned;
  logic        tgt_in_range;
  logic        instr_valid;

  assign pc_in_range  = (pc_q[31:IMEM_W] == '0);
  assign tgt_aligned  = (bus.redirect_target[1:0] == 2'b00);
  assign tgt_in_range = (bus.redirect_target[31:IMEM_W] == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      trap_cause_q <= 2'd0;
      trap_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      trap_cause_q <= trap_cause_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    trap_cause_d = trap_cause_q;
    trap_pc_d    = trap_pc_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // Out-of-window PC outranks any redirect arriving in the same cycle.
        if (!pc_in_range) begin
          state_d      = TRAP;
          trap_cause_d = 2'd2;
          trap_pc_d    = pc_q;
        end else if (bus.redirect_valid) begin
          if (!tgt_aligned) begin
            state_d      = TRAP;
            trap_cause_d = 2'd1;
            trap_pc_d    = bus.redirect_target;
          end else begin
            pc_d = bus.redirect_target;
          end
        end else if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      TRAP: begin
        if (bus.redirect_valid && tgt_aligned && tgt_in_range) begin
          state_d      = RUN;
          pc_d         = bus.redirect_target;
          trap_cause_d = 2'd0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    instr_valid     = (state_q == RUN) && pc_in_range;
    bus.instr_valid = instr_valid;
    bus.instr       = instr_valid ? bus.imem_rdata : NOP;
    bus.pc          = pc_q;
    bus.pc_plus4    = pc_q + 32'd4;
    bus.imem_raddr  = pc_q[IMEM_W-1:0];
    bus.trap_cause  = trap_cause_q;
    bus.trap_pc     = trap_pc_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
    end else if (instr_valid && !bus.stall && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_cnt = fetch_cnt_q;
`else
  assign bus.fetch_cnt = 32'h0;
`endif
endmodule
